// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALU controls, M-extension ops,
// forwarding selects and the multiply/divide sequencer states.
package execute_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        MOP_MUL    = 3'd0,
        MOP_MULH   = 3'd1,
        MOP_MULHSU = 3'd2,
        MOP_MULHU  = 3'd3,
        MOP_DIV    = 3'd4,
        MOP_DIVU   = 3'd5,
        MOP_REM    = 3'd6,
        MOP_REMU   = 3'd7
    } mop_e;

    typedef enum logic [1:0] {
        FWD_RD   = 2'd0,
        FWD_W    = 2'd1,
        FWD_M    = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit: shift-add multiply / restoring divide on magnitudes, one bit per cycle.
// Latency XLEN+1 from start (1 for divide-by-zero / signed overflow); busy is the stall request.
module muldiv_iter import execute_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    md_state_e       state, state_nx;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, dvs;
    logic [2:0]      op_q;
    logic            neg_q, neg_r;

    logic            is_div, a_sgn, b_sgn, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_div   = op[2];
    assign a_sgn    = a[XLEN-1] & (op == MOP_MULH || op == MOP_MULHSU || op == MOP_DIV || op == MOP_REM);
    assign b_sgn    = b[XLEN-1] & (op == MOP_MULH || op == MOP_DIV || op == MOP_REM);
    assign a_mag    = a_sgn ? -a : a;
    assign b_mag    = b_sgn ? -b : b;
    assign div_zero = is_div & (b == '0);
    assign div_ovf  = is_div & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            MD_IDLE: if (start) begin
                busy     = 1'b1;
                state_nx = special ? MD_DONE : MD_BUSY;
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (cnt == CW'(XLEN-1)) state_nx = MD_DONE;
            end
            MD_DONE: begin
                done     = 1'b1;
                state_nx = MD_IDLE;
            end
            default: state_nx = MD_IDLE;
        endcase
        if (flush) begin
            state_nx = MD_IDLE;
            done     = 1'b0;
        end
    end

    // One iteration step for each algorithm
    logic [XLEN:0]   sum, trial;
    logic            q_bit;
    logic [XLEN-1:0] rem_sub;

    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    assign trial   = {hi, lo[XLEN-1]};
    assign q_bit   = (trial >= {1'b0, dvs});
    assign rem_sub = trial[XLEN-1:0] - dvs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == MD_IDLE && start) begin
                op_q <= op;
                cnt  <= '0;
                dvs  <= is_div ? b_mag : a_mag;
                if (special) begin
                    // Results are preloaded so the normal output path emits them unchanged
                    lo    <= div_zero ? '1 : a;
                    hi    <= div_zero ? a : '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                end else begin
                    lo    <= is_div ? a_mag : b_mag;
                    hi    <= '0;
                    neg_q <= a_sgn ^ b_sgn;
                    neg_r <= a_sgn;
                end
            end else if (state == MD_BUSY) begin
                cnt <= cnt + CW'(1);
                if (op_q[2]) begin
                    hi <= q_bit ? rem_sub : trial[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], q_bit};
                end else begin
                    hi <= sum[XLEN:1];
                    lo <= {sum[0], lo[XLEN-1:1]};
                end
            end
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
    assign quo_s  = neg_q ? -lo : lo;
    assign rem_s  = neg_r ? -hi : hi;

    always_comb begin
        result = '0;
        if (op_q[2])                 result = op_q[1] ? rem_s : quo_s;
        else if (op_q == MOP_MUL)    result = prod_s[XLEN-1:0];
        else                         result = prod_s[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/execute_md.sv
// Execute stage with forwarding, ALU, branch resolution, M-extension unit and the E/M register.
// Latency 1 cycle (iterative M ops XLEN+1); BusyE stalls upstream while E/M loads bubbles.
module execute_md import execute_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ALUSrcAE,
    input  logic            ALUSrcBE,
    input  logic            MulDivE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUCtrlE,
    input  logic [2:0]      funct3E,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] inc_PCE,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUoutM_i,
    input  logic            FlushE,
    output logic [XLEN-1:0] PCTarget,
    output logic            PCSrc,
    output logic            BusyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [2:0]      funct3M,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUoutM_o,
    output logic [XLEN-1:0] inc_PCM
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] fa, fb, srca, srcb, alu_res;
    logic [SW-1:0]   shamt;

    always_comb begin
        case (ForwardA)
            FWD_RD:  fa = RD1E;
            FWD_W:   fa = ResultW;
            FWD_M:   fa = ALUoutM_i;
            default: fa = '0;
        endcase
        case (ForwardB)
            FWD_RD:  fb = RD2E;
            FWD_W:   fb = ResultW;
            FWD_M:   fb = ALUoutM_i;
            default: fb = '0;
        endcase
    end

    assign srca  = ALUSrcAE ? PCE : fa;
    assign srcb  = ALUSrcBE ? ImmExtE : fb;
    assign shamt = srcb[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (ALUCtrlE)
            ALU_ADD:   alu_res = srca + srcb;
            ALU_SUB:   alu_res = srca - srcb;
            ALU_AND:   alu_res = srca & srcb;
            ALU_OR:    alu_res = srca | srcb;
            ALU_XOR:   alu_res = srca ^ srcb;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
            ALU_SLL:   alu_res = srca << shamt;
            ALU_SRL:   alu_res = srca >> shamt;
            ALU_SRA:   alu_res = $signed(srca) >>> shamt;
            ALU_PASSB: alu_res = srcb;
            default:   alu_res = '0;
        endcase
    end

    // Branch relation uses the forwarded register values, not the ALU sources
    logic rel;
    always_comb begin
        rel = 1'b0;
        case (funct3E)
            BR_EQ:   rel = (fa == fb);
            BR_NE:   rel = (fa != fb);
            BR_LT:   rel = ($signed(fa) <  $signed(fb));
            BR_GE:   rel = ($signed(fa) >= $signed(fb));
            BR_LTU:  rel = (fa <  fb);
            BR_GEU:  rel = (fa >= fb);
            default: rel = 1'b0;
        endcase
    end

    assign PCSrc    = ValidE & ~FlushE & ((BranchE & rel) | JumpE);
    assign PCTarget = alu_res;

    // Single-cycle multiplier: sign-extend to 2*XLEN and keep the low product bits
    logic              fast_op, fm_sa, fm_sb;
    logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
    logic [XLEN-1:0]   fast_res;

    assign fast_op  = (FAST_MUL != 0) && !funct3E[2];
    assign fm_sa    = (funct3E == MOP_MULH) || (funct3E == MOP_MULHSU);
    assign fm_sb    = (funct3E == MOP_MULH);
    assign fm_a     = {{XLEN{fm_sa & srca[XLEN-1]}}, srca};
    assign fm_b     = {{XLEN{fm_sb & srcb[XLEN-1]}}, srcb};
    assign fm_p     = fm_a * fm_b;
    assign fast_res = (funct3E == MOP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];

    logic            md_start, md_busy, md_done;
    logic [XLEN-1:0] md_result;

    assign md_start = ValidE & MulDivE & ~FlushE & ~fast_op;

    muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .flush  (FlushE),
        .op     (funct3E),
        .a      (srca),
        .b      (srcb),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign BusyE = md_busy;

    logic            load;
    logic [XLEN-1:0] ex_res;

    assign load   = ValidE & ~FlushE & ~md_busy & (~MulDivE | fast_op | md_done);
    assign ex_res = MulDivE ? (fast_op ? fast_res : md_result) : alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            funct3M    <= '0;
            RdM        <= '0;
            ALUoutM_o  <= '0;
            inc_PCM    <= '0;
        end else if (load) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            funct3M    <= funct3E;
            RdM        <= RdE;
            ALUoutM_o  <= ex_res;
            inc_PCM    <= inc_PCE;
        end else begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            funct3M    <= '0;
            RdM        <= '0;
            ALUoutM_o  <= '0;
            inc_PCM    <= '0;
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: iterative (dut) and single-cycle-multiply (dut_f) instances share stimulus.
module tb_execute_md;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidE, JumpE, BranchE, RegWriteE, MemWriteE, ALUSrcAE, ALUSrcBE, MulDivE, FlushE;
    logic [1:0]  ResultSrcE, ForwardA, ForwardB;
    logic [3:0]  ALUCtrlE;
    logic [2:0]  funct3E;
    logic [4:0]  RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, inc_PCE, ResultW, ALUoutM_i;

    logic [31:0] PCTarget, ALUoutM_o, inc_PCM;
    logic        PCSrc, BusyE, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;

    logic [31:0] PCTarget_f, ALUoutM_o_f, inc_PCM_f;
    logic        PCSrc_f, BusyE_f, RegWriteM_f, MemWriteM_f;
    logic [1:0]  ResultSrcM_f;
    logic [2:0]  funct3M_f;
    logic [4:0]  RdM_f;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_md #(.XLEN(32), .FAST_MUL(0)) dut (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .JumpE(JumpE), .BranchE(BranchE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .MulDivE(MulDivE), .ResultSrcE(ResultSrcE), .ALUCtrlE(ALUCtrlE), .funct3E(funct3E),
        .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .inc_PCE(inc_PCE),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .ResultW(ResultW), .ALUoutM_i(ALUoutM_i),
        .FlushE(FlushE), .PCTarget(PCTarget), .PCSrc(PCSrc), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .RdM(RdM), .ALUoutM_o(ALUoutM_o), .inc_PCM(inc_PCM)
    );

    execute_md #(.XLEN(32), .FAST_MUL(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .JumpE(JumpE), .BranchE(BranchE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .MulDivE(MulDivE), .ResultSrcE(ResultSrcE), .ALUCtrlE(ALUCtrlE), .funct3E(funct3E),
        .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .inc_PCE(inc_PCE),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .ResultW(ResultW), .ALUoutM_i(ALUoutM_i),
        .FlushE(FlushE), .PCTarget(PCTarget_f), .PCSrc(PCSrc_f), .BusyE(BusyE_f),
        .RegWriteM(RegWriteM_f), .MemWriteM(MemWriteM_f), .ResultSrcM(ResultSrcM_f),
        .funct3M(funct3M_f), .RdM(RdM_f), .ALUoutM_o(ALUoutM_o_f), .inc_PCM(inc_PCM_f)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        ValidE = 0; JumpE = 0; BranchE = 0; RegWriteE = 0; MemWriteE = 0;
        ALUSrcAE = 0; ALUSrcBE = 0; MulDivE = 0; FlushE = 0;
        ResultSrcE = 0; ForwardA = 0; ForwardB = 0; ALUCtrlE = 0; funct3E = 0; RdE = 0;
        RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; inc_PCE = 0; ResultW = 0; ALUoutM_i = 0;
    endtask

    // Issues one M op held in E until the stall clears, then checks cycle count and E/M result
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc,
                          output logic f_busy_seen);
        int   cyc;
        logic rw_seen;
        @(negedge clk);
        set_idle();
        ValidE = 1; MulDivE = 1; RegWriteE = 1; funct3E = f3; RD1E = a; RD2E = b; RdE = 5'd10;
        #1;
        cyc = 0; rw_seen = 0; f_busy_seen = 0;
        while (BusyE && cyc < 100) begin
            cyc++;
            rw_seen     = rw_seen | RegWriteM;
            f_busy_seen = f_busy_seen | BusyE_f;
            if (cyc == 5 && f3[2]) begin
                ForwardA = 2'b11;
                ForwardB = 2'b11;
            end
            @(negedge clk);
            #1;
        end
        f_busy_seen = f_busy_seen | BusyE_f;
        check({tag, " busy cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " no write while busy"}, 64'(rw_seen), 64'd0);
        @(negedge clk);
        #1;
        check({tag, " result"}, 64'(ALUoutM_o), 64'(exp));
        check({tag, " RegWriteM"}, 64'(RegWriteM), 64'd1);
        check({tag, " RdM"}, 64'(RdM), 64'd10);
        check({tag, " fast inst result"}, 64'(ALUoutM_o_f), 64'(exp));
        set_idle();
    endtask

    initial begin
        logic fb;
        int   k;
        logic rw;

        set_idle();
        ValidE = 0; RD1E = 32'h1234; RD2E = 32'h1234; BranchE = 1; JumpE = 1;
        rst_n = 0;
        #12;
        check("reset BusyE", 64'(BusyE), 64'd0);
        check("reset RegWriteM", 64'(RegWriteM), 64'd0);
        check("reset ALUoutM_o", 64'(ALUoutM_o), 64'd0);
        check("reset PCSrc", 64'(PCSrc), 64'd0);
        check("reset inc_PCM", 64'(inc_PCM), 64'd0);
        set_idle();
        @(negedge clk);
        rst_n = 1;

        // ADD 5 + 7
        @(negedge clk);
        ValidE = 1; RegWriteE = 1; ALUCtrlE = 4'd0; RD1E = 5; RD2E = 7; RdE = 3;
        ResultSrcE = 2'b01; funct3E = 3'b010; inc_PCE = 32'h104;
        #1;
        check("add BusyE", 64'(BusyE), 64'd0);
        @(negedge clk);
        #1;
        check("add result", 64'(ALUoutM_o), 64'd12);
        check("add RegWriteM", 64'(RegWriteM), 64'd1);
        check("add RdM", 64'(RdM), 64'd3);
        check("add ResultSrcM", 64'(ResultSrcM), 64'd1);
        check("add funct3M", 64'(funct3M), 64'd2);
        check("add inc_PCM", 64'(inc_PCM), 64'h104);

        // SUB with both operands forwarded: 50 - 8
        set_idle();
        ValidE = 1; RegWriteE = 1; ALUCtrlE = 4'd1; ForwardA = 2'b01; ResultW = 50;
        ForwardB = 2'b10; ALUoutM_i = 8; RD1E = 99; RD2E = 99; RdE = 7;
        @(negedge clk);
        #1;
        check("sub fwd result", 64'(ALUoutM_o), 64'd42);

        // ValidE low loads a bubble
        set_idle();
        RegWriteE = 1; MemWriteE = 1; RD1E = 1; RD2E = 1;
        @(negedge clk);
        #1;
        check("invalid RegWriteM", 64'(RegWriteM), 64'd0);
        check("invalid MemWriteM", 64'(MemWriteM), 64'd0);

        // BEQ with ForwardA from M stage, ALUoutM_i = RD2E = 9
        set_idle();
        ValidE = 1; BranchE = 1; funct3E = 3'b000; ForwardA = 2'b10; ALUoutM_i = 9; RD2E = 9;
        RD1E = 3; ALUSrcAE = 1; ALUSrcBE = 1; PCE = 32'h1000; ImmExtE = 32'h20; ALUCtrlE = 4'd0;
        #1;
        check("beq taken PCSrc", 64'(PCSrc), 64'd1);
        check("beq PCTarget", 64'(PCTarget), 64'h1020);
        RD2E = 8;
        #1;
        check("beq not taken PCSrc", 64'(PCSrc), 64'd0);
        ForwardA = 2'b11; RD2E = 0;
        #1;
        check("beq zero fwd PCSrc", 64'(PCSrc), 64'd1);
        funct3E = 3'b100; ForwardA = 2'b00; RD1E = 32'hFFFF_FFFE; RD2E = 1;
        #1;
        check("blt signed PCSrc", 64'(PCSrc), 64'd1);
        funct3E = 3'b110;
        #1;
        check("bltu PCSrc", 64'(PCSrc), 64'd0);
        FlushE = 1; JumpE = 1;
        #1;
        check("flushed jump PCSrc", 64'(PCSrc), 64'd0);
        set_idle();

        run_md("divu 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33, fb);
        run_md("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, fb);
        run_md("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, fb);
        run_md("remu 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 1, fb);
        run_md("divu 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, fb);
        run_md("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, fb);
        run_md("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, fb);
        run_md("mulh -2*3", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, fb);
        check("mulh fast BusyE never", 64'(fb), 64'd0);
        run_md("mul 7*6", 3'd0, 32'd7, 32'd6, 32'd42, 33, fb);
        check("mul fast BusyE never", 64'(fb), 64'd0);
        run_md("mulhu max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, fb);
        run_md("mulhsu -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, fb);

        @(negedge clk);
        #1;
        check("bubble after md", 64'(RegWriteM), 64'd0);

        // Flush on busy cycle 10, then an ADD must complete in one cycle
        @(negedge clk);
        ValidE = 1; MulDivE = 1; RegWriteE = 1; funct3E = 3'd5; RD1E = 100; RD2E = 7;
        repeat (10) @(negedge clk);
        #1;
        check("flush pre BusyE", 64'(BusyE), 64'd1);
        FlushE = 1;
        @(negedge clk);
        set_idle();
        ValidE = 1; RegWriteE = 1; ALUCtrlE = 4'd0; RD1E = 1; RD2E = 2; RdE = 4;
        #1;
        check("flush idle BusyE", 64'(BusyE), 64'd0);
        check("flush bubble RegWriteM", 64'(RegWriteM), 64'd0);
        @(negedge clk);
        #1;
        check("post flush add", 64'(ALUoutM_o), 64'd3);
        check("post flush RegWriteM", 64'(RegWriteM), 64'd1);
        check("post flush RdM", 64'(RdM), 64'd4);
        set_idle();

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        ValidE = 1; MulDivE = 1; RegWriteE = 1; funct3E = 3'd5; RD1E = 100; RD2E = 7; RdE = 9;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 0;
        ValidE = 0;
        #1;
        check("rst mid BusyE", 64'(BusyE), 64'd0);
        check("rst mid RegWriteM", 64'(RegWriteM), 64'd0);
        check("rst mid ALUoutM_o", 64'(ALUoutM_o), 64'd0);
        check("rst mid RdM", 64'(RdM), 64'd0);
        check("rst mid PCSrc", 64'(PCSrc), 64'd0);
        @(negedge clk);
        rst_n = 1;
        set_idle();
        rw = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            rw = rw | RegWriteM | BusyE;
        end
        check("rst abort no write", 64'(rw), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
